// File: rtl/fq_pkg.sv
// Shared definitions for the instruction fetch queue: bubble word,
// entry field layout and pointer-width helper.
package fq_pkg;

  // Instruction word shown to the decoder when no valid entry is at the head.
  localparam logic [31:0] FQ_BUBBLE_INSTR = 32'h0000_0000;

  // Entry layout, LSB first: {pc, instr, pred}.
  localparam int FQ_PRED_BIT  = 0;
  localparam int FQ_INSTR_LSB = 1;

  function automatic int fq_pc_lsb(input int size);
    return size + 1;
  endfunction

  function automatic int fq_entry_w(input int size);
    return 2 * size + 1;
  endfunction

  // Pointer width for a DEPTH-entry circular buffer.
  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: register array with one synchronous
// write port and one asynchronous read port. Contents are not reset.
module fetch_queue_ram #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between Fetch and Decoder: DEPTH-entry circular
// buffer of {pc, instr, pred} with back-pressure, flush and bubble injection.
// Optional macro FQ_BYPASS_EN: an empty queue with a ready decoder forwards
// the offered entry straight to the outputs in the same cycle.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int              SIZE   = 32,
  parameter int              DEPTH  = 4,
  parameter logic [SIZE-1:0] BUBBLE = SIZE'(FQ_BUBBLE_INSTR)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE-1:0]          in_pc,
  input  logic [SIZE-1:0]          in_instr,
  input  logic                     in_pred,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_pc,
  output logic [SIZE-1:0]          out_instr,
  output logic                     out_pred,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = fq_ptr_w(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = fq_entry_w(SIZE);
  localparam int PC_LSB  = fq_pc_lsb(SIZE);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SIZE-1:0]    last_pc_q, last_pc_d;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] wr_entry;
  logic               not_empty;
  logic               bypass;
  logic               push;
  logic               pop;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));

`ifdef FQ_BYPASS_EN
  assign bypass = ~not_empty & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed directly, so it is never written.
  assign push     = in_valid & in_ready & ~flush & ~bypass;
  assign pop      = not_empty & ~flush & out_ready;
  assign wr_entry = {in_pc, in_instr, in_pred};

  fetch_queue_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // Head presentation: bypass entry, stored head, or bubble with the last
  // presented PC held stable.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = last_pc_q;
    out_instr = BUBBLE;
    out_pred  = 1'b0;
    if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
      out_pred  = in_pred;
    end else if (not_empty && !flush) begin
      out_valid = 1'b1;
      out_pc    = head_entry[PC_LSB +: SIZE];
      out_instr = head_entry[FQ_INSTR_LSB +: SIZE];
      out_pred  = head_entry[FQ_PRED_BIT];
    end
  end

  // Next-state for pointers, occupancy and held PC; flush overrides all.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    last_pc_d = out_valid ? out_pc : last_pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_pred;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_queue #(.SIZE(32), .DEPTH(DEPTH), .BUBBLE(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_pred   (in_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_pred  (out_pred),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a plain queue of {pc, instr, pred}.
  logic [64:0] model_q[$];

  function automatic logic model_bypass();
`ifdef FQ_BYPASS_EN
    return (model_q.size() == 0) && in_valid && out_ready && !flush;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic logic do_pop  = (model_q.size() > 0) && out_ready;
      automatic logic do_push = in_valid && (model_q.size() < DEPTH) && !model_bypass();
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_pc, in_instr, in_pred});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    automatic logic        e_valid;
    automatic logic [31:0] e_pc    = 32'h0;
    automatic logic [31:0] e_instr = 32'h0;
    automatic logic        e_pred  = 1'b0;
    if (model_bypass()) begin
      e_valid = 1'b1;
      e_pc = in_pc; e_instr = in_instr; e_pred = in_pred;
    end else begin
      e_valid = (model_q.size() > 0) && !flush && reset;
      if (e_valid) begin
        e_pc    = model_q[0][64:33];
        e_instr = model_q[0][32:1];
        e_pred  = model_q[0][0];
      end
    end
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    chk("m_out_instr", out_instr, e_instr);
    chk("m_out_pred", {31'b0, out_pred}, {31'b0, e_pred});
    if (e_valid) chk("m_out_pc", out_pc, e_pc);
    chk("m_count", {29'b0, count}, 32'(model_q.size()));
    chk("m_in_ready", {31'b0, in_ready}, {31'b0, (model_q.size() != DEPTH)});
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0050_0093 + (pc << 18);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic p, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    in_pred   = p;
    out_ready = rdy;
  endtask

  initial begin
    int popped;
    logic [31:0] next_pc;
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset and empty.
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_count", {29'b0, count}, 32'h0);
    tick();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("idle_out_valid", {31'b0, out_valid}, 32'h0);
    chk("idle_count", {29'b0, count}, 32'h0);
    tick();

    // Fill with back-pressure.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", {29'b0, count}, 32'h4);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    chk("full_model_size", 32'(model_q.size()), 32'h4);
    tick();
    @(negedge clk);
    chk("held_out_pc", out_pc, 32'h0);
    chk("held_count", {29'b0, count}, 32'h4);
    tick();

    // Drain in order across the pointer wrap while pushing 0x10..0x1C.
    popped = 0;
    next_pc = 32'h10;
    for (int cyc = 0; cyc < 40 && popped < 8; cyc++) begin
      drive(next_pc <= 32'h1C, next_pc, 1'b0, 1'b1);
      @(negedge clk);
      if (out_valid) begin
        chk("drain_order", out_pc, 32'(popped * 4));
        popped++;
      end
      if (in_valid && in_ready) next_pc += 32'h4;
      tick();
    end
    vectors++;
    if (popped != 8) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pops expected 8", popped);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Flush from count=3 with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_count_before", {29'b0, count}, 32'h3);
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_out_instr", out_instr, 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_count", {29'b0, count}, 32'h0);
    chk("post_flush_valid", {31'b0, out_valid}, 32'h0);
    tick();
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_flush_valid", {31'b0, out_valid}, 32'h1);
    chk("after_flush_pc", out_pc, 32'h80);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Prediction bit.
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pred_pc0", out_pc, 32'h20);
    chk("pred_bit0", {31'b0, out_pred}, 32'h1);
    tick();
    @(negedge clk);
    chk("pred_pc1", out_pc, 32'h24);
    chk("pred_bit1", {31'b0, out_pred}, 32'h0);
    tick();
    @(negedge clk);
    chk("pred_bubble", {31'b0, out_pred}, 32'h0);
    chk("pred_bubble_instr", out_instr, 32'h0);
    tick();

    // Empty queue with input offered and decoder ready.
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    @(negedge clk);
`ifdef FQ_BYPASS_EN
    chk("byp_same_valid", {31'b0, out_valid}, 32'h1);
    chk("byp_same_pc", out_pc, 32'h100);
`else
    chk("byp_same_valid", {31'b0, out_valid}, 32'h0);
`endif
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
`ifdef FQ_BYPASS_EN
    chk("byp_next_count", {29'b0, count}, 32'h0);
    chk("byp_next_valid", {31'b0, out_valid}, 32'h0);
`else
    chk("byp_next_valid", {31'b0, out_valid}, 32'h1);
    chk("byp_next_pc", out_pc, 32'h100);
`endif
    tick();
    tick();

    // Reset asserted mid-operation.
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_count", {29'b0, count}, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_rst_pc", out_pc, 32'h200);
    chk("after_rst_count", {29'b0, count}, 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
